// File: rtl/mtr_drv.sv
// Motor gate-drive stage: free-running 2048-clock PWM, per-coil select decode and
// per-coil non-overlap (deadtime) units driving six FET gates, plus the period strobe.
module mtr_drv #(
  parameter int DEADTIME = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] duty,
  input  logic [1:0]  selGrn,
  input  logic [1:0]  selYlw,
  input  logic [1:0]  selBlu,
  output logic        PWM_synch,
  output logic        highGrn,
  output logic        lowGrn,
  output logic        highYlw,
  output logic        lowYlw,
  output logic        highBlu,
  output logic        lowBlu
);

  localparam logic [6:0] DT = 7'(DEADTIME);

  typedef enum logic [1:0] {
    HIGH_Z   = 2'b00,
    LOW_PWM  = 2'b01,
    HIGH_PWM = 2'b10,
    BRAKE    = 2'b11
  } sel_e;

  // Requested gate pair, packed as {high, low}.
  function automatic logic [1:0] decode_req(input logic [1:0] sel, input logic pwm);
    logic [1:0] req;
    case (sel)
      HIGH_PWM: req = {pwm, ~pwm};
      LOW_PWM:  req = {~pwm, pwm};
      BRAKE:    req = {1'b0, pwm};
      default:  req = 2'b00;
    endcase
    return req;
  endfunction

  logic [10:0] r_cnt;
  logic [10:0] r_duty_q;
  logic        r_pwm;
  logic        w_wrap;

  assign w_wrap    = (r_cnt == 11'h7FF);
  assign PWM_synch = w_wrap;

  // PWM stage: duty is only sampled at the period boundary so a period is never torn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= 11'd0;
      r_duty_q <= 11'd0;
      r_pwm    <= 1'b0;
    end else begin
      r_cnt <= r_cnt + 11'd1;
      if (w_wrap) r_duty_q <= duty;
      r_pwm <= (r_cnt < r_duty_q);
    end
  end

  logic [1:0] w_sel      [3];
  logic [1:0] w_req      [3];
  logic [6:0] w_dcnt_nxt [3];
  logic [1:0] w_gate_nxt [3];
  logic [1:0] r_pair     [3];
  logic [6:0] r_dcnt     [3];
  logic [1:0] r_gate     [3];

  assign w_sel[0] = selGrn;
  assign w_sel[1] = selYlw;
  assign w_sel[2] = selBlu;

  // Any change of the request pair (select or pwm edge, or both together) restarts deadtime.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_req[i]      = decode_req(w_sel[i], r_pwm);
      w_dcnt_nxt[i] = 7'd0;
      w_gate_nxt[i] = 2'b00;
      if (w_req[i] == r_pair[i])
        w_dcnt_nxt[i] = (r_dcnt[i] == DT) ? r_dcnt[i] : r_dcnt[i] + 7'd1;
      if (w_dcnt_nxt[i] == DT)
        w_gate_nxt[i] = w_req[i];
    end
  end

  // Non-overlap stage: gates are registered so they never glitch on the request decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        r_pair[i] <= 2'b00;
        r_dcnt[i] <= 7'd0;
        r_gate[i] <= 2'b00;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        r_pair[i] <= w_req[i];
        r_dcnt[i] <= w_dcnt_nxt[i];
        r_gate[i] <= w_gate_nxt[i];
      end
    end
  end

  assign highGrn = r_gate[0][1];
  assign lowGrn  = r_gate[0][0];
  assign highYlw = r_gate[1][1];
  assign lowYlw  = r_gate[1][0];
  assign highBlu = r_gate[2][1];
  assign lowBlu  = r_gate[2][0];

endmodule

// File: tb/tb_mtr_drv.sv
// Directed bench for mtr_drv: reset, PWM strobe period, per-select gate widths,
// duty capture at period boundary, short-duty and deadtime latency/restart behaviour.
module tb_mtr_drv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] duty = 11'd0;
  logic [1:0]  selGrn = 2'b00, selYlw = 2'b00, selBlu = 2'b00;
  logic        PWM_synch;
  logic        highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu;

  int n_chk  = 0;
  int n_fail = 0;
  int n_ovl  = 0;
  int c_hg, c_lg, c_hy, c_ly, c_hb, c_lb, c_gz;

  always #10 clk = ~clk;

  mtr_drv #(.DEADTIME(32)) dut (
    .clk(clk), .rst_n(rst_n), .duty(duty),
    .selGrn(selGrn), .selYlw(selYlw), .selBlu(selBlu),
    .PWM_synch(PWM_synch),
    .highGrn(highGrn), .lowGrn(lowGrn),
    .highYlw(highYlw), .lowYlw(lowYlw),
    .highBlu(highBlu), .lowBlu(lowBlu)
  );

  // Shoot-through watch over the entire run.
  always @(negedge clk)
    if ((highGrn && lowGrn) || (highYlw && lowYlw) || (highBlu && lowBlu)) n_ovl++;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_synch();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!PWM_synch && k < 4096);
    if (!PWM_synch) chk("synch_timeout", k, -1);
  endtask

  // Counts gate-high cycles over 2048 consecutive samples starting at the current negedge.
  task automatic measure(input int chg_idx, input logic [10:0] chg_duty);
    c_hg = 0; c_lg = 0; c_hy = 0; c_ly = 0; c_hb = 0; c_lb = 0; c_gz = 0;
    for (int k = 0; k < 2048; k++) begin
      if (k == chg_idx) duty = chg_duty;
      c_hg += int'(highGrn); c_lg += int'(lowGrn);
      c_hy += int'(highYlw); c_ly += int'(lowYlw);
      c_hb += int'(highBlu); c_lb += int'(lowBlu);
      c_gz += int'(!highGrn && !lowGrn);
      @(negedge clk);
    end
  endtask

  task automatic count_until_high(input int which, output int n, output int other_seen);
    logic hit;
    n = 0; other_seen = 0; hit = 1'b0;
    while (!hit && n < 200) begin
      @(negedge clk);
      n++;
      case (which)
        0: begin hit = lowGrn;  other_seen += int'(highGrn); end
        1: begin hit = highGrn; other_seen += int'(lowGrn);  end
        default: begin hit = lowYlw; other_seen += int'(highYlw); end
      endcase
    end
  endtask

  int n, other, gates_on;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_gates", int'({highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu}), 0);
    chk("rst_synch", int'(PWM_synch), 0);

    // Release with everything HIGH_Z: first strobe 2047 clocks after release, then every 2048
    rst_n = 1'b1;
    n = 0; gates_on = 0;
    do begin
      @(negedge clk);
      n++;
      gates_on += int'(highGrn | lowGrn | highYlw | lowYlw | highBlu | lowBlu);
    end while (!PWM_synch && n < 5000);
    chk("first_synch", n, 2047);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      gates_on += int'(highGrn | lowGrn | highYlw | lowYlw | highBlu | lowBlu);
    end while (!PWM_synch && n < 5000);
    chk("synch_period", n, 2048);
    chk("hiz_gates", gates_on, 0);

    // Green HIGH_PWM, duty 0x600: 1536 high / 512 low, minus 32 each
    selGrn = 2'b10; duty = 11'h600;
    wait_synch(); wait_synch();
    measure(-1, 11'h600);
    chk("g600_high", c_hg, 1504);
    chk("g600_low", c_lg, 480);
    chk("g600_gap", c_gz, 64);

    // duty 0x400: green HIGH_PWM, yellow LOW_PWM, blue BRAKE
    selYlw = 2'b01; selBlu = 2'b11; duty = 11'h400;
    wait_synch(); wait_synch();
    measure(-1, 11'h400);
    chk("g400_high", c_hg, 992);
    chk("y400_high", c_hy, 992);
    chk("y400_low", c_ly, 992);
    chk("b400_high", c_hb, 0);
    chk("b400_low", c_lb, 992);

    // Duty change at cnt=0x100 (sample 0x101 of a window starting at cnt=0x7FF)
    measure(16'h101, 11'h200);
    chk("dchg_cur_high", c_hg, 992);
    measure(-1, 11'h200);
    chk("dchg_next_high", c_hg, 480);

    // Short duty: high never asserts, low 2032-32
    selYlw = 2'b00; selBlu = 2'b00; duty = 11'h010;
    wait_synch(); wait_synch();
    measure(-1, 11'h010);
    chk("d010_high", c_hg, 0);
    chk("d010_low", c_lg, 2000);

    duty = 11'h000;
    wait_synch(); wait_synch();
    measure(-1, 11'h000);
    chk("d000_high", c_hg, 0);
    chk("d000_low", c_lg, 2048);

    // pwm now constant 0; yellow low side on steadily
    selYlw = 2'b10;
    selGrn = 2'b00;
    repeat (40) @(negedge clk);
    chk("ylw_low_on", int'(lowYlw), 1);

    // Latency: edge after the change is N, gate asserts at N+32 (33rd negedge)
    selGrn = 2'b10;
    count_until_high(0, n, other);
    chk("latency", n, 33);

    // Toggle inside deadtime: count restarts from the last change
    selGrn = 2'b00;
    repeat (40) @(negedge clk);
    selGrn = 2'b10;
    repeat (10) @(negedge clk);
    selGrn = 2'b01;
    count_until_high(1, n, other);
    chk("toggle_latency", n, 33);
    chk("toggle_low_seen", other, 0);

    // Reset while green is at dcnt=10 and yellow low side is on
    selGrn = 2'b10;
    repeat (11) @(negedge clk);
    chk("pre_rst_ylw", int'(lowYlw), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_gates", int'({highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    count_until_high(2, n, other);
    chk("post_rst_latency", n, 33);
    chk("post_rst_grn_low", int'(lowGrn), 1);

    chk("overlap", n_ovl, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
